// File: rtl/audio_pkg.sv
// Shared audio-path types and constants used by the mixer and the I2S output stage.
package audio_pkg;

  localparam int SAMPLE_WIDTH   = 16;
  localparam int I2S_SLOT_WIDTH = 16;

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] left;
    logic [SAMPLE_WIDTH-1:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/i2s_clock_gen.sv
// Bit-clock divider: produces audio_bclk and a strobe on the clk edge where bclk falls.
module i2s_clock_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic audio_bclk,
  output logic fall_evt
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  logic          wrap;

  assign wrap = (div_cnt_q == CW'(CLK_DIV - 1));

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    div_cnt_d = div_cnt_q;
    bclk_d    = bclk_q;
    fall_evt  = 1'b0;
    if (!enable) begin
      div_cnt_d = '0;
      bclk_d    = 1'b0;
    end else if (wrap) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
      fall_evt  = bclk_q;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign audio_bclk = bclk_q;

endmodule

// File: rtl/i2s_transmitter.sv
// I2S output stage: one-deep frame buffer with bypass, bit counter and frame shifter
// driving bclk/lrclk/dout; all data and word-select updates happen on bclk fall edges.
module i2s_transmitter #(
  parameter int CLK_DIV      = 8,
  parameter int SAMPLE_WIDTH = audio_pkg::SAMPLE_WIDTH,
  parameter int SLOT_WIDTH   = audio_pkg::I2S_SLOT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [SAMPLE_WIDTH-1:0] s_left,
  input  logic [SAMPLE_WIDTH-1:0] s_right,
  output logic                    frame_start,
  output logic                    underrun,
  output logic                    audio_bclk,
  output logic                    audio_lrclk,
  output logic                    audio_dout
);

  import audio_pkg::*;

  localparam int FW = 2 * SLOT_WIDTH;
  localparam int BW = $clog2(FW);
  localparam logic [BW-1:0] LAST_BIT = BW'(FW - 1);

  function automatic logic [SLOT_WIDTH-1:0] pad(input logic [SAMPLE_WIDTH-1:0] s);
    return SLOT_WIDTH'(s) << (SLOT_WIDTH - SAMPLE_WIDTH);
  endfunction

  logic           fall_evt;
  logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [FW-1:0]  shift_q, shift_d;
  stereo_sample_t pend_q, pend_d;
  logic           pend_full_q, pend_full_d;
  logic           lrclk_q, lrclk_d;
  logic           dout_q, dout_d;
  logic           frame_start_q, frame_start_d;
  logic           underrun_q, underrun_d;
  logic           transfer, load;

  i2s_clock_gen #(.CLK_DIV(CLK_DIV)) u_clock_gen (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .audio_bclk (audio_bclk),
    .fall_evt   (fall_evt)
  );

  assign transfer = s_valid && !pend_full_q;
  assign load     = fall_evt && (bit_cnt_q == LAST_BIT);

  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    pend_d        = pend_q;
    pend_full_d   = pend_full_q;
    lrclk_d       = lrclk_q;
    dout_d        = dout_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;

    if (!enable) begin
      // Parked at the last bit so the first fall after re-enable loads a fresh frame.
      bit_cnt_d = LAST_BIT;
      shift_d   = '0;
      lrclk_d   = 1'b0;
      dout_d    = 1'b0;
    end else if (fall_evt) begin
      bit_cnt_d = load ? '0 : bit_cnt_q + 1'b1;
      dout_d    = shift_q[FW-1];
      shift_d   = shift_q << 1;
      lrclk_d   = (bit_cnt_d >= BW'(SLOT_WIDTH));
    end

    if (load) begin
      frame_start_d = 1'b1;
      if (pend_full_q) begin
        shift_d     = {pad(pend_q.left), pad(pend_q.right)};
        pend_full_d = 1'b0;
      end else if (transfer) begin
        shift_d = {pad(s_left), pad(s_right)};
      end else begin
        shift_d    = '0;
        underrun_d = 1'b1;
      end
    end else if (transfer) begin
      pend_d      = '{left: s_left, right: s_right};
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q     <= LAST_BIT;
      shift_q       <= '0;
      pend_q        <= '0;
      pend_full_q   <= 1'b0;
      lrclk_q       <= 1'b0;
      dout_q        <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      pend_q        <= pend_d;
      pend_full_q   <= pend_full_d;
      lrclk_q       <= lrclk_d;
      dout_q        <= dout_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign s_ready     = !pend_full_q;
  assign audio_lrclk = lrclk_q;
  assign audio_dout  = dout_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter at default parameters (CLK_DIV=8, 16-bit samples and slots).
module tb_i2s_transmitter;

  logic        clk = 1'b0;
  logic        rst, enable, s_valid;
  logic [15:0] s_left, s_right;
  logic        s_ready, frame_start, underrun;
  logic        audio_bclk, audio_lrclk, audio_dout;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  i2s_transmitter dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_left      (s_left),
    .s_right     (s_right),
    .frame_start (frame_start),
    .underrun    (underrun),
    .audio_bclk  (audio_bclk),
    .audio_lrclk (audio_lrclk),
    .audio_dout  (audio_dout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Holds reset for two clks, then releases it with enable=1; cyc counts clks from release.
  task automatic start_run();
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0;
    step();
    step();
    enable = 1'b1;
    rst    = 1'b0;
    cyc    = 0;
  endtask

  task automatic wait_fall(input string name);
    logic prev;
    bit   ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      prev = audio_bclk;
      step();
      if (prev && !audio_bclk) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL %s: no bclk fall within 64 clk", name);
    end
  endtask

  task automatic wait_frame_start(input string name, input int limit);
    while (!frame_start && cyc < limit) step();
    tests++;
    if (!(frame_start === 1'b1 && cyc == 16)) begin
      fails++;
      $display("FAIL %s: frame_start=%b at clk %0d, need 1 at clk 16", name, frame_start, cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0;
    step();
    tests++;
    if ({audio_bclk, audio_lrclk, audio_dout, frame_start, underrun, s_ready} !== 6'b000001) begin
      fails++;
      $display("FAIL reset_values: got %b need 000001",
               {audio_bclk, audio_lrclk, audio_dout, frame_start, underrun, s_ready});
    end
    enable = 1'b1;
    repeat (20) step();
    tests++;
    if ({audio_bclk, audio_lrclk, audio_dout, frame_start, underrun, s_ready} !== 6'b000001) begin
      fails++;
      $display("FAIL reset_hold_enabled: got %b need 000001",
               {audio_bclk, audio_lrclk, audio_dout, frame_start, underrun, s_ready});
    end
  endtask

  task automatic test_first_frame();
    logic [31:0] dout_vec, lr_vec;
    start_run();
    s_valid = 1'b1; s_left = 16'hA5F0; s_right = 16'h0F0F;
    step();
    s_valid = 1'b0;
    tests++;
    if (s_ready !== 1'b0) begin
      fails++;
      $display("FAIL first_buffered: s_ready=%b need 0", s_ready);
    end
    wait_frame_start("first_frame_start", 40);
    dout_vec = '0;
    lr_vec   = '0;
    lr_vec[31] = audio_lrclk;
    for (int k = 1; k <= 32; k++) begin
      wait_fall("first_frame_fall");
      dout_vec[32-k] = audio_dout;
      if (k <= 31) lr_vec[31-k] = audio_lrclk;
    end
    tests++;
    if (dout_vec !== 32'hA5F0_0F0F) begin
      fails++;
      $display("FAIL first_dout: got %h need a5f00f0f", dout_vec);
    end
    tests++;
    if (lr_vec !== 32'h0000_FFFF) begin
      fails++;
      $display("FAIL first_lrclk: got %h need 0000ffff", lr_vec);
    end
    tests++;
    if ({frame_start, underrun} !== 2'b11) begin
      fails++;
      $display("FAIL first_next_underrun: fs/ur=%b need 11", {frame_start, underrun});
    end
  endtask

  task automatic test_underrun();
    int   ur_cyc[4];
    int   n_ur, dout_ones, not_ready, bclk_tog, lr_tog;
    logic pb, pl;
    n_ur = 0; dout_ones = 0; not_ready = 0; bclk_tog = 0; lr_tog = 0;
    start_run();
    while (cyc < 1100) begin
      pb = audio_bclk; pl = audio_lrclk;
      step();
      if (underrun) begin
        if (n_ur < 4) ur_cyc[n_ur] = cyc;
        n_ur++;
      end
      if (audio_dout)          dout_ones++;
      if (!s_ready)            not_ready++;
      if (pb != audio_bclk)    bclk_tog++;
      if (pl != audio_lrclk)   lr_tog++;
    end
    tests++;
    if (n_ur != 3 || ur_cyc[0] != 16 || ur_cyc[1] != 528 || ur_cyc[2] != 1040) begin
      fails++;
      $display("FAIL underrun_pulses: count %0d first at %0d/%0d/%0d, need 3 at 16/528/1040",
               n_ur, ur_cyc[0], ur_cyc[1], ur_cyc[2]);
    end
    tests++;
    if (dout_ones != 0 || not_ready != 0) begin
      fails++;
      $display("FAIL underrun_idle: dout high %0d clks, s_ready low %0d clks, need 0/0",
               dout_ones, not_ready);
    end
    tests++;
    if (bclk_tog != 137 || lr_tog != 4) begin
      fails++;
      $display("FAIL underrun_clocks: bclk toggles %0d lrclk toggles %0d, need 137/4",
               bclk_tog, lr_tog);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] fl[3];
    logic [15:0] fr[3];
    logic [95:0] vec;
    int   idx, falls, loads, urs, ur_load, ready_bad;
    logic xfer, prev;
    fl[0] = 16'h1234; fr[0] = 16'h5678;
    fl[1] = 16'h9ABC; fr[1] = 16'hDEF0;
    fl[2] = 16'h0F1E; fr[2] = 16'h2D3C;
    vec = '0; idx = 0; falls = 0; loads = 0; urs = 0; ur_load = 0; ready_bad = 0;
    start_run();
    repeat (15) step();
    s_valid = 1'b1; s_left = fl[0]; s_right = fr[0];
    while (falls < 97 && cyc < 2000) begin
      xfer = s_valid && s_ready;
      prev = audio_bclk;
      step();
      if (xfer) begin
        idx++;
        if (idx < 3) begin
          s_left = fl[idx]; s_right = fr[idx];
        end else begin
          s_valid = 1'b0;
        end
      end
      if (cyc == 17) begin
        tests++;
        if (s_ready !== 1'b0) begin
          fails++;
          $display("FAIL b2b_buffer_fill: s_ready=%b at clk 17 need 0", s_ready);
        end
      end
      if (frame_start) begin
        loads++;
        if (s_ready !== 1'b1) ready_bad++;
      end
      if (underrun) begin
        urs++;
        ur_load = loads;
      end
      if (prev && !audio_bclk) begin
        falls++;
        if (falls >= 2) vec = {vec[94:0], audio_dout};
      end
    end
    tests++;
    if (vec !== {fl[0], fr[0], fl[1], fr[1], fl[2], fr[2]}) begin
      fails++;
      $display("FAIL b2b_data: got %h need %h", vec, {fl[0], fr[0], fl[1], fr[1], fl[2], fr[2]});
    end
    tests++;
    if (loads != 4 || urs != 1 || ur_load != 4 || ready_bad != 0) begin
      fails++;
      $display("FAIL b2b_flow: loads %0d underruns %0d (on load %0d) ready-low-after-load %0d, need 4/1/4/0",
               loads, urs, ur_load, ready_bad);
    end
  endtask

  task automatic test_bypass_on_load();
    start_run();
    repeat (15) step();
    s_valid = 1'b1; s_left = 16'h8001; s_right = 16'h7FFE;
    step();
    s_valid = 1'b0;
    tests++;
    if ({frame_start, underrun, s_ready} !== 3'b101) begin
      fails++;
      $display("FAIL bypass_load: fs/ur/ready=%b need 101", {frame_start, underrun, s_ready});
    end
    step();
    tests++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL bypass_buffer_empty: s_ready=%b need 1", s_ready);
    end
    wait_fall("bypass_p1");
    tests++;
    if (audio_dout !== 1'b1 || audio_lrclk !== 1'b0) begin
      fails++;
      $display("FAIL bypass_left_msb: dout/lrclk=%b%b need 10", audio_dout, audio_lrclk);
    end
    repeat (15) wait_fall("bypass_p16");
    tests++;
    if (audio_dout !== 1'b1 || audio_lrclk !== 1'b1) begin
      fails++;
      $display("FAIL bypass_left_lsb: dout/lrclk=%b%b need 11", audio_dout, audio_lrclk);
    end
    wait_fall("bypass_p17");
    tests++;
    if (audio_dout !== 1'b0) begin
      fails++;
      $display("FAIL bypass_right_msb: dout=%b need 0", audio_dout);
    end
    repeat (15) wait_fall("bypass_p32");
    tests++;
    if ({audio_dout, audio_lrclk, frame_start, underrun} !== 4'b0011) begin
      fails++;
      $display("FAIL bypass_right_lsb: dout/lrclk/fs/ur=%b need 0011",
               {audio_dout, audio_lrclk, frame_start, underrun});
    end
  endtask

  task automatic test_reset_mid_frame();
    start_run();
    s_valid = 1'b1; s_left = 16'h1111; s_right = 16'hFFFF;
    step();
    s_valid = 1'b0;
    wait_frame_start("rstmid_first_load", 40);
    s_valid = 1'b1; s_left = 16'h2222; s_right = 16'h3333;
    step();
    s_valid = 1'b0;
    repeat (20) wait_fall("rstmid_p20");
    tests++;
    if ({audio_lrclk, audio_dout, s_ready} !== 3'b110) begin
      fails++;
      $display("FAIL rstmid_before: lrclk/dout/ready=%b need 110", {audio_lrclk, audio_dout, s_ready});
    end
    repeat (8) step();
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({audio_bclk, audio_lrclk, audio_dout, frame_start, underrun, s_ready} !== 6'b000001) begin
      fails++;
      $display("FAIL rstmid_async: got %b need 000001",
               {audio_bclk, audio_lrclk, audio_dout, frame_start, underrun, s_ready});
    end
    step();
    step();
    rst = 1'b0;
    cyc = 0;
    wait_frame_start("rstmid_restart", 40);
    tests++;
    if (underrun !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_pending_discarded: underrun=%b need 1", underrun);
    end
  endtask

  task automatic test_enable_drop();
    int          bad;
    logic [31:0] vec;
    bad = 0;
    vec = '0;
    start_run();
    s_valid = 1'b1; s_left = 16'h0040; s_right = 16'h0000;
    step();
    s_valid = 1'b0;
    wait_frame_start("endrop_first_load", 40);
    s_valid = 1'b1; s_left = 16'hC3A5; s_right = 16'h5A3C;
    step();
    s_valid = 1'b0;
    repeat (10) wait_fall("endrop_p10");
    repeat (8) step();
    tests++;
    if ({audio_bclk, audio_dout, s_ready} !== 3'b110) begin
      fails++;
      $display("FAIL endrop_before: bclk/dout/ready=%b need 110", {audio_bclk, audio_dout, s_ready});
    end
    enable = 1'b0;
    step();
    tests++;
    if ({audio_bclk, audio_lrclk, audio_dout, s_ready} !== 4'b0000) begin
      fails++;
      $display("FAIL endrop_pins: bclk/lrclk/dout/ready=%b need 0000",
               {audio_bclk, audio_lrclk, audio_dout, s_ready});
    end
    repeat (40) begin
      step();
      if (audio_bclk || audio_lrclk || audio_dout || frame_start || underrun || s_ready) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL endrop_idle: %0d clks with activity or s_ready high, need 0", bad);
    end
    enable = 1'b1;
    cyc = 0;
    wait_frame_start("endrop_reenable", 40);
    tests++;
    if ({underrun, s_ready} !== 2'b01) begin
      fails++;
      $display("FAIL endrop_pending_load: ur/ready=%b need 01", {underrun, s_ready});
    end
    for (int k = 1; k <= 32; k++) begin
      wait_fall("endrop_frame_fall");
      vec[32-k] = audio_dout;
    end
    tests++;
    if (vec !== 32'hC3A5_5A3C) begin
      fails++;
      $display("FAIL endrop_data: got %h need c3a55a3c", vec);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_underrun();
    test_back_to_back();
    test_bypass_on_load();
    test_reset_mid_frame();
    test_enable_drop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
